// File: rtl/inta_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : inta_sequencer
//  Description : CPU-side interrupt-acknowledge initiator for an 8259A PIC.
//                Drives the 8086 two-pulse or MCS-80 three-pulse INTA#
//                sequence, samples the PIC data bus at the end of each pulse
//                and hands the assembled vector to the CPU via valid/ready.
//                Optional feature macro: INTA_OPCODE_CHECK_EN
//                (MCS-80 first-byte CALL opcode check).
//  Revision    : 1.0 - initial release
// ============================================================================
module inta_sequencer #(
  parameter int INTA_LOW_CYCLES = 2,
  parameter int INTA_GAP_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        interrupt_to_cpu,
  input  logic        interrupt_enable,
  input  logic        mode_8086,
  input  logic [7:0]  data_bus_in,
  output logic        interrupt_acknowledge_n,
  output logic        busy,
  output logic        vector_valid,
  input  logic        vector_ready,
  output logic [15:0] vector_data,
  output logic        opcode_error
);

  // Phase counter only has to count down from max(LOW, GAP)-1 to zero.
  localparam int c_MAX_CYCLES = (INTA_LOW_CYCLES > INTA_GAP_CYCLES) ?
                                INTA_LOW_CYCLES : INTA_GAP_CYCLES;
  localparam int c_CNT_W      = (c_MAX_CYCLES > 1) ? $clog2(c_MAX_CYCLES) : 1;

  localparam logic [c_CNT_W-1:0] c_LOW_LOAD = c_CNT_W'(INTA_LOW_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_GAP_LOAD = c_CNT_W'(INTA_GAP_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_CNT_ZERO = '0;
  localparam logic [7:0]         c_CALL_OP  = 8'hCD;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOW1 = 3'd1,
    S_GAP1 = 3'd2,
    S_LOW2 = 3'd3,
    S_GAP2 = 3'd4,
    S_LOW3 = 3'd5,
    S_HOLD = 3'd6
  } state_t;

  state_t             r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_mode_8086;
  logic               r_inta_n;
  logic               r_vector_valid;
  logic [15:0]        r_vector_data;

`ifdef INTA_OPCODE_CHECK_EN
  logic [7:0]         r_opcode;
  logic               r_opcode_error;
`endif

  // Sequencer: walks the pulse/gap phases, captures bus bytes on the edge
  // that ends each low phase, and holds the vector until the CPU takes it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_cnt          <= c_CNT_ZERO;
      r_mode_8086    <= 1'b0;
      r_inta_n       <= 1'b1;
      r_vector_valid <= 1'b0;
      r_vector_data  <= 16'h0000;
`ifdef INTA_OPCODE_CHECK_EN
      r_opcode       <= 8'h00;
      r_opcode_error <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          // Mode is frozen here so a mid-sequence change cannot alter
          // the pulse count the PIC is expecting.
          if (interrupt_to_cpu && interrupt_enable) begin
            r_state     <= S_LOW1;
            r_inta_n    <= 1'b0;
            r_cnt       <= c_LOW_LOAD;
            r_mode_8086 <= mode_8086;
          end
        end

        S_LOW1: begin
          if (r_cnt == c_CNT_ZERO) begin
            r_state  <= S_GAP1;
            r_inta_n <= 1'b1;
            r_cnt    <= c_GAP_LOAD;
`ifdef INTA_OPCODE_CHECK_EN
            r_opcode <= data_bus_in;
`endif
          end else begin
            r_cnt <= r_cnt - c_CNT_ONE;
          end
        end

        S_GAP1: begin
          if (r_cnt == c_CNT_ZERO) begin
            r_state  <= S_LOW2;
            r_inta_n <= 1'b0;
            r_cnt    <= c_LOW_LOAD;
          end else begin
            r_cnt <= r_cnt - c_CNT_ONE;
          end
        end

        S_LOW2: begin
          if (r_cnt == c_CNT_ZERO) begin
            r_inta_n <= 1'b1;
            if (r_mode_8086) begin
              // 8086: second byte is the interrupt type; sequence done.
              r_vector_data  <= {8'h00, data_bus_in};
              r_vector_valid <= 1'b1;
              r_state        <= S_HOLD;
            end else begin
              r_vector_data[7:0] <= data_bus_in;
              r_cnt              <= c_GAP_LOAD;
              r_state            <= S_GAP2;
            end
          end else begin
            r_cnt <= r_cnt - c_CNT_ONE;
          end
        end

        S_GAP2: begin
          if (r_cnt == c_CNT_ZERO) begin
            r_state  <= S_LOW3;
            r_inta_n <= 1'b0;
            r_cnt    <= c_LOW_LOAD;
          end else begin
            r_cnt <= r_cnt - c_CNT_ONE;
          end
        end

        S_LOW3: begin
          if (r_cnt == c_CNT_ZERO) begin
            r_inta_n            <= 1'b1;
            r_vector_data[15:8] <= data_bus_in;
            r_vector_valid      <= 1'b1;
            r_state             <= S_HOLD;
`ifdef INTA_OPCODE_CHECK_EN
            // Flag raised alongside valid so the CPU sees both together.
            r_opcode_error      <= (r_opcode != c_CALL_OP);
`endif
          end else begin
            r_cnt <= r_cnt - c_CNT_ONE;
          end
        end

        S_HOLD: begin
          if (vector_ready) begin
            r_vector_valid <= 1'b0;
            r_state        <= S_IDLE;
`ifdef INTA_OPCODE_CHECK_EN
            r_opcode_error <= 1'b0;
`endif
          end
        end

        default: begin
          r_state        <= S_IDLE;
          r_inta_n       <= 1'b1;
          r_vector_valid <= 1'b0;
        end
      endcase
    end
  end

  assign interrupt_acknowledge_n = r_inta_n;
  assign vector_valid            = r_vector_valid;
  assign vector_data             = r_vector_data;
  assign busy                    = (r_state != S_IDLE);

`ifdef INTA_OPCODE_CHECK_EN
  assign opcode_error = r_opcode_error;
`else
  assign opcode_error = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_inta_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inta_sequencer
//  Description : Directed self-checking bench for inta_sequencer with
//                L = G = 2. Opcode-flag expectations follow the
//                INTA_OPCODE_CHECK_EN macro.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inta_sequencer;

`ifdef INTA_OPCODE_CHECK_EN
  localparam logic c_OE_BAD = 1'b1;
`else
  localparam logic c_OE_BAD = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic        interrupt_to_cpu;
  logic        interrupt_enable;
  logic        mode_8086;
  logic [7:0]  data_bus_in;
  logic        interrupt_acknowledge_n;
  logic        busy;
  logic        vector_valid;
  logic        vector_ready;
  logic [15:0] vector_data;
  logic        opcode_error;

  int n_err;
  int n_chk;

  inta_sequencer #(
    .INTA_LOW_CYCLES (2),
    .INTA_GAP_CYCLES (2)
  ) u_dut (
    .clock                   (clock),
    .reset                   (reset),
    .interrupt_to_cpu        (interrupt_to_cpu),
    .interrupt_enable        (interrupt_enable),
    .mode_8086               (mode_8086),
    .data_bus_in             (data_bus_in),
    .interrupt_acknowledge_n (interrupt_acknowledge_n),
    .busy                    (busy),
    .vector_valid            (vector_valid),
    .vector_ready            (vector_ready),
    .vector_data             (vector_data),
    .opcode_error            (opcode_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [15:0] obs,
                          input logic [15:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One full acknowledge sequence starting on the next edge (E0). INT and IF
  // are dropped in GAP1 and the mode input is flipped after E0; neither may
  // disturb the sequence. hold = cycles the CPU stalls in HOLD; hold = 0
  // means vector_ready is already high before the vector appears.
  task automatic do_seq(input logic m, input logic [7:0] b1,
                        input logic [7:0] b2, input logic [7:0] b3,
                        input int hold, input logic exp_oe);
    int          last;
    logic [15:0] exp_vec;
    logic        exp_n;
    last    = m ? 6 : 10;
    exp_vec = m ? {8'h00, b2} : {b3, b2};
    interrupt_to_cpu = 1'b1;
    interrupt_enable = 1'b1;
    mode_8086        = m;
    data_bus_in      = b1;
    vector_ready     = (hold == 0);
    for (int k = 0; k <= last; k++) begin
      step();
      exp_n = ((k % 4) < 2 && k < last) ? 1'b0 : 1'b1;
      check_eq($sformatf("inta_n_E%0d", k), {15'd0, interrupt_acknowledge_n},
               {15'd0, exp_n});
      if (k < last)
        check_eq($sformatf("valid_E%0d", k), {15'd0, vector_valid}, 16'd0);
      if (k == 0) mode_8086 = ~m;
      if (k == 2) begin
        interrupt_to_cpu = 1'b0;
        interrupt_enable = 1'b0;
        data_bus_in      = b2;
      end
      if (k == 6) data_bus_in = b3;
    end
    check_eq("hold_valid", {15'd0, vector_valid}, 16'd1);
    check_eq("hold_data",  vector_data, exp_vec);
    check_eq("hold_busy",  {15'd0, busy}, 16'd1);
    check_eq("hold_oe",    {15'd0, opcode_error}, {15'd0, exp_oe});
    for (int h = 0; h < hold; h++) begin
      data_bus_in = 8'($urandom);
      step();
      check_eq("stall_valid", {15'd0, vector_valid}, 16'd1);
      check_eq("stall_data",  vector_data, exp_vec);
    end
    vector_ready = 1'b1;
    step();
    check_eq("post_valid", {15'd0, vector_valid}, 16'd0);
    check_eq("post_busy",  {15'd0, busy}, 16'd0);
    check_eq("post_oe",    {15'd0, opcode_error}, 16'd0);
    check_eq("post_inta",  {15'd0, interrupt_acknowledge_n}, 16'd1);
    vector_ready = 1'b0;
    step();
    check_eq("idle_busy", {15'd0, busy}, 16'd0);
  endtask

  initial begin
    n_err            = 0;
    n_chk            = 0;
    reset            = 1'b1;
    interrupt_to_cpu = 1'b0;
    interrupt_enable = 1'b0;
    mode_8086        = 1'b1;
    data_bus_in      = 8'h00;
    vector_ready     = 1'b0;

    step();
    check_eq("rst_inta",  {15'd0, interrupt_acknowledge_n}, 16'd1);
    check_eq("rst_busy",  {15'd0, busy}, 16'd0);
    check_eq("rst_valid", {15'd0, vector_valid}, 16'd0);
    check_eq("rst_data",  vector_data, 16'h0000);
    check_eq("rst_oe",    {15'd0, opcode_error}, 16'd0);
    reset = 1'b0;
    step();
    step();

    // 8086 two-pulse sequence, CPU stalls one cycle.
    do_seq(1'b1, 8'h11, 8'h4A, 8'h00, 1, 1'b0);

    // MCS-80 three-pulse sequence, CPU stalls five cycles.
    do_seq(1'b0, 8'hCD, 8'h38, 8'h12, 5, 1'b0);

    // INT masked by IF for 20 cycles.
    interrupt_to_cpu = 1'b1;
    interrupt_enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check_eq("masked_inta", {15'd0, interrupt_acknowledge_n}, 16'd1);
      check_eq("masked_busy", {15'd0, busy}, 16'd0);
    end
    // Raising IF starts an 8086 sequence on the very next edge; ready early.
    do_seq(1'b1, 8'h99, 8'h5C, 8'h00, 0, 1'b0);

    // Reset mid-LOW2 in MCS-80 mode.
    interrupt_to_cpu = 1'b1;
    interrupt_enable = 1'b1;
    mode_8086        = 1'b0;
    data_bus_in      = 8'hCD;
    for (int i = 0; i < 6; i++) step();
    check_eq("low2_inta", {15'd0, interrupt_acknowledge_n}, 16'd0);
    reset = 1'b1;
    #1;
    check_eq("mrst_inta",  {15'd0, interrupt_acknowledge_n}, 16'd1);
    check_eq("mrst_valid", {15'd0, vector_valid}, 16'd0);
    check_eq("mrst_busy",  {15'd0, busy}, 16'd0);
    check_eq("mrst_data",  vector_data, 16'h0000);
    #1;
    reset = 1'b0;
    do_seq(1'b0, 8'hCD, 8'h21, 8'h43, 2, 1'b0);

    // Bad MCS-80 opcode, then a good one.
    do_seq(1'b0, 8'hC3, 8'h01, 8'h02, 2, c_OE_BAD);
    do_seq(1'b0, 8'hCD, 8'h03, 8'h04, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
